imm_reg_bank: RTL and testbench

//  Multi-entry immediate staging bank for the decode/execute path: DEPTH entries of DATA_W bits, each

---
 rtl/imm_pkg.sv | 12 +
 rtl/imm_reg_entry.sv | 51 +++++
 rtl/imm_reg_bank.sv | 130 +++++++++++++
 tb/tb_imm_reg_bank.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Package shared by the immediate staging bank.
//   DEF_DATA_W / DEF_DEPTH : default entry width and entry count
//   EXT_ZERO / EXT_SIGN    : encoding of rd_sext for single-entry reads
package imm_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

endpackage : imm_pkg

// File: rtl/imm_reg_entry.sv
// One entry of the immediate staging bank: DATA_W data bits plus a valid flag.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears data and valid)
//   wr, wdata       : write strobe (already decoded for this entry) and data
//   clr, clr_bit    : bit-clear strobe (decoded) and bit index; indices >= DATA_W do nothing
//   inv             : drop the valid flag (a same-cycle write still sets it)
//   data_q, vld_q   : current state
//   data_d, vld_d   : next state, exported so the read path can bypass
module imm_reg_entry #(
  parameter int DATA_W = 8,
  parameter int BW     = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  input  logic [BW-1:0]     clr_bit,
  input  logic              inv,
  output logic [DATA_W-1:0] data_q,
  output logic              vld_q,
  output logic [DATA_W-1:0] data_d,
  output logic              vld_d
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] clr_mask;

  always_comb begin
    // Shifting past the top bit yields an all-zero pattern, so an
    // out-of-range clr_bit produces an all-ones mask and is ignored.
    clr_mask = ~(ONE << clr_bit);
    data_d   = wr ? wdata : data_q;
    if (clr) begin
      data_d = data_d & clr_mask;
    end
    vld_d = wr ? 1'b1 : (inv ? 1'b0 : vld_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

endmodule : imm_reg_entry

// File: rtl/imm_reg_bank.sv
// Immediate staging bank: DEPTH entries of DATA_W bits with active-low write,
// single-bit clear, per-entry valid and a registered read port (latency 1).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   wr_en_n, wr_addr, imm8_in  : active-low write of one entry
//   clr_en, clr_addr, clr_bit  : clear one bit of one entry
//   inv_all                    : drop all valid bits (data retained)
//   rd_req, rd_addr            : read request and (lo) entry address
//   rd_pair                    : 1 = {entry[rd_addr+1], entry[rd_addr]}
//   rd_sext                    : single read sign (1) / zero (0) extension
//   imm_out, rd_valid, rd_err  : registered read result, valid pulse, error
//   valid_vec                  : per-entry valid bits
module imm_reg_bank
  import imm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = $clog2(DEPTH),
  parameter int BW     = $clog2(DATA_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_n,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DATA_W-1:0]   imm8_in,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  input  logic [BW-1:0]       clr_bit,
  input  logic                inv_all,
  input  logic                rd_req,
  input  logic [AW-1:0]       rd_addr,
  input  logic                rd_pair,
  input  logic                rd_sext,
  output logic [2*DATA_W-1:0] imm_out,
  output logic                rd_valid,
  output logic                rd_err,
  output logic [DEPTH-1:0]    valid_vec
);

  function automatic logic [2*DATA_W-1:0] extend(input logic [DATA_W-1:0] e,
                                                 input logic              mode);
    logic fill;
    fill = (mode == EXT_ZERO) ? 1'b0 : e[DATA_W-1];
    return {{DATA_W{fill}}, e};
  endfunction

  logic [DEPTH-1:0]  wr_sel;
  logic [DEPTH-1:0]  clr_sel;
  logic [DATA_W-1:0] ent_q   [DEPTH];
  logic [DATA_W-1:0] ent_d   [DEPTH];
  logic [DATA_W-1:0] rd_src  [DEPTH];
  logic [DEPTH-1:0]  ent_vld_q;
  logic [DEPTH-1:0]  ent_vld_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wr_sel[i]  = !wr_en_n && (wr_addr == AW'(i));
      clr_sel[i] = clr_en && (clr_addr == AW'(i));
      // Entries touched this cycle are read from their next state (bypass).
      rd_src[i]  = (wr_sel[i] || clr_sel[i]) ? ent_d[i] : ent_q[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    imm_reg_entry #(
      .DATA_W (DATA_W),
      .BW     (BW)
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr_sel[g]),
      .wdata   (imm8_in),
      .clr     (clr_sel[g]),
      .clr_bit (clr_bit),
      .inv     (inv_all),
      .data_q  (ent_q[g]),
      .vld_q   (ent_vld_q[g]),
      .data_d  (ent_d[g]),
      .vld_d   (ent_vld_d[g])
    );
  end

  assign valid_vec = ent_vld_q;

  // Read mux: next-state sources, extension / pair concatenation.
  logic [AW-1:0]       hi_addr;
  logic [DATA_W-1:0]   lo_data;
  logic [DATA_W-1:0]   hi_data;
  logic                src_err;
  logic [2*DATA_W-1:0] rd_data;

  always_comb begin
    hi_addr = rd_addr + AW'(1);   // wraps DEPTH-1 -> 0
    lo_data = rd_src[rd_addr];
    hi_data = rd_src[hi_addr];
    src_err = !ent_vld_d[rd_addr] || (rd_pair && !ent_vld_d[hi_addr]);
    rd_data = rd_pair ? {hi_data, lo_data} : extend(lo_data, rd_sext);
  end

  logic [2*DATA_W-1:0] imm_q, imm_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_err_q, rd_err_d;

  always_comb begin
    imm_d      = imm_q;
    rd_valid_d = rd_req;
    rd_err_d   = rd_req && src_err;
    if (rd_req) begin
      imm_d = src_err ? '0 : rd_data;
    end
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      imm_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      imm_q      <= imm_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign imm_out  = imm_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;

endmodule : imm_reg_bank

// File: tb/tb_imm_reg_bank.sv
module tb_imm_reg_bank;

  logic        clk = 1'b0;
  logic        reset, wr_en_n, clr_en, inv_all, rd_req, rd_pair, rd_sext;
  logic [1:0]  wr_addr, clr_addr, rd_addr;
  logic [7:0]  imm8_in;
  logic [2:0]  clr_bit;
  logic [15:0] imm_out;
  logic        rd_valid, rd_err;
  logic [3:0]  valid_vec;

  imm_reg_bank dut (
    .clk(clk), .reset(reset), .wr_en_n(wr_en_n), .wr_addr(wr_addr), .imm8_in(imm8_in),
    .clr_en(clr_en), .clr_addr(clr_addr), .clr_bit(clr_bit), .inv_all(inv_all),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_pair(rd_pair), .rd_sext(rd_sext),
    .imm_out(imm_out), .rd_valid(rd_valid), .rd_err(rd_err), .valid_vec(valid_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wen_n;
    logic [1:0] wa;
    logic [7:0] din;
    logic       clr;
    logic [1:0] ca;
    logic [2:0] cb;
    logic       inv;
    logic       req;
    logic [1:0] ra;
    logic       pair;
    logic       sext;
  } in_t;

  typedef struct {
    in_t         in;
    logic [15:0] imm;
    logic        rv;
    logic        err;
    logic [3:0]  vv;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: bank contents as plain arrays.
  int  m_mem [4];
  bit  m_vld [4];
  int  m_imm;
  bit  m_rv, m_err;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_step(input in_t x);
    int nm [4];
    bit nv [4];
    int lo, hi, hia, val;
    bit err;
    if (x.rst) begin
      for (int i = 0; i < 4; i++) begin m_mem[i] = 0; m_vld[i] = 0; end
      m_imm = 0; m_rv = 0; m_err = 0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      nm[i] = m_mem[i];
      nv[i] = x.inv ? 1'b0 : m_vld[i];
    end
    if (!x.wen_n) begin
      nm[x.wa] = x.din;
      nv[x.wa] = 1;
    end
    if (x.clr) nm[x.ca] = nm[x.ca] & ~(1 << x.cb) & 255;
    m_rv  = x.req;
    m_err = 0;
    if (x.req) begin
      lo  = nm[x.ra];
      hia = (x.ra + 1) % 4;
      hi  = nm[hia];
      if (x.pair) begin
        val = hi * 256 + lo;
        err = !nv[x.ra] || !nv[hia];
      end else begin
        val = (x.sext && lo >= 128) ? lo + 16'hFF00 : lo;
        err = !nv[x.ra];
      end
      m_err = err;
      m_imm = err ? 0 : val;
    end
    for (int i = 0; i < 4; i++) begin m_mem[i] = nm[i]; m_vld[i] = nv[i]; end
  endfunction

  function automatic int model_vv();
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_vld[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic apply(input in_t x);
    reset = x.rst; wr_en_n = x.wen_n; wr_addr = x.wa; imm8_in = x.din;
    clr_en = x.clr; clr_addr = x.ca; clr_bit = x.cb; inv_all = x.inv;
    rd_req = x.req; rd_addr = x.ra; rd_pair = x.pair; rd_sext = x.sext;
    @(posedge clk);
    model_step(x);
    #1;
  endtask

  function automatic in_t mk(input bit rst, input bit wen_n, input int wa, input int din,
                             input bit clr, input int ca, input int cb, input bit inv,
                             input bit req, input int ra, input bit pair, input bit sext);
    in_t x;
    x.rst = rst; x.wen_n = wen_n; x.wa = 2'(wa); x.din = 8'(din);
    x.clr = clr; x.ca = 2'(ca); x.cb = 3'(cb); x.inv = inv;
    x.req = req; x.ra = 2'(ra); x.pair = pair; x.sext = sext;
    return x;
  endfunction

  vec_t tbl [20];

  initial begin
    //             rst wen wa din  clr ca cb inv req ra pr sx      imm     rv err vv
    tbl[0]  = '{mk(1, 0, 0, 'hAA, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, 0, 0, 4'b0000};
    tbl[1]  = '{mk(1, 0, 1, 'hBB, 0, 0, 0, 0, 1, 0, 0, 0), 16'h0000, 0, 0, 4'b0000};
    tbl[2]  = '{mk(0, 1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, 0, 0, 4'b0000};
    tbl[3]  = '{mk(0, 0, 2, 'h85, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, 0, 0, 4'b0100};
    tbl[4]  = '{mk(0, 1, 0, 'h00, 0, 0, 0, 0, 1, 2, 0, 1), 16'hFF85, 1, 0, 4'b0100};
    tbl[5]  = '{mk(0, 1, 0, 'h00, 0, 0, 0, 0, 1, 2, 0, 0), 16'h0085, 1, 0, 4'b0100};
    tbl[6]  = '{mk(0, 1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0085, 0, 0, 4'b0100};
    tbl[7]  = '{mk(0, 0, 1, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0085, 0, 0, 4'b0110};
    tbl[8]  = '{mk(0, 1, 0, 'h00, 1, 1, 3, 0, 0, 0, 0, 0), 16'h0085, 0, 0, 4'b0110};
    tbl[9]  = '{mk(0, 1, 0, 'h00, 0, 0, 0, 0, 1, 1, 0, 0), 16'h00F7, 1, 0, 4'b0110};
    tbl[10] = '{mk(0, 0, 1, 'hFF, 1, 1, 7, 0, 1, 1, 0, 1), 16'h007F, 1, 0, 4'b0110};
    tbl[11] = '{mk(0, 0, 3, 'h12, 0, 0, 0, 0, 0, 0, 0, 0), 16'h007F, 0, 0, 4'b1110};
    tbl[12] = '{mk(0, 0, 0, 'h34, 0, 0, 0, 0, 0, 0, 0, 0), 16'h007F, 0, 0, 4'b1111};
    tbl[13] = '{mk(0, 1, 0, 'h00, 0, 0, 0, 0, 1, 3, 1, 0), 16'h3412, 1, 0, 4'b1111};
    tbl[14] = '{mk(0, 0, 2, 'h99, 0, 0, 0, 1, 0, 0, 0, 0), 16'h3412, 0, 0, 4'b0100};
    tbl[15] = '{mk(0, 1, 0, 'h00, 0, 0, 0, 0, 1, 1, 0, 0), 16'h0000, 1, 1, 4'b0100};
    tbl[16] = '{mk(0, 0, 0, 'h5A, 0, 0, 0, 0, 1, 0, 0, 1), 16'h005A, 1, 0, 4'b0101};
    tbl[17] = '{mk(0, 1, 0, 'h00, 0, 0, 0, 0, 1, 0, 1, 0), 16'h0000, 1, 1, 4'b0101};
    tbl[18] = '{mk(0, 1, 0, 'h00, 0, 0, 0, 0, 1, 2, 0, 1), 16'hFF99, 1, 0, 4'b0101};
    tbl[19] = '{mk(1, 1, 0, 'h00, 0, 0, 0, 0, 1, 2, 0, 1), 16'h0000, 0, 0, 4'b0000};

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].in);
      check($sformatf("row%0d imm_out", i), int'(imm_out), int'(tbl[i].imm));
      check($sformatf("row%0d rd_valid", i), int'(rd_valid), int'(tbl[i].rv));
      check($sformatf("row%0d rd_err", i), int'(rd_err), int'(tbl[i].err));
      check($sformatf("row%0d valid_vec", i), int'(valid_vec), int'(tbl[i].vv));
    end

    // Read issued, then reset on the following cycle drops the result.
    apply(mk(0, 0, 1, 'hC3, 0, 0, 0, 0, 1, 1, 0, 1));
    check("seq read before reset", int'(imm_out), 16'hFFC3);
    apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    check("seq reset rd_valid", int'(rd_valid), 0);
    check("seq reset imm_out", int'(imm_out), 0);
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("seq post-reset rd_valid", int'(rd_valid), 0);

    // Randomized phase against the reference model.
    for (int n = 0; n < 400; n++) begin
      in_t x;
      x = mk($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3),
             $urandom_range(0, 255), $urandom_range(0, 3) == 0, $urandom_range(0, 3),
             $urandom_range(0, 7), $urandom_range(0, 15) == 0, $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
      apply(x);
      check($sformatf("rnd%0d imm_out", n), int'(imm_out), m_imm);
      check($sformatf("rnd%0d rd_valid", n), int'(rd_valid), int'(m_rv));
      check($sformatf("rnd%0d rd_err", n), int'(rd_err), int'(m_err));
      check($sformatf("rnd%0d valid_vec", n), int'(valid_vec), model_vv());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_imm_reg_bank
